// File: rtl/edge_pkg.sv
// Shared types and sizes for the edge detector tile feeder.
package edge_pkg;

    localparam int unsigned TILE_N  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned FLUSH_W = 4;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [2:0] {
        LOAD,
        EMIT,
        FLUSH,
        WAIT_DONE,
        CLEAR
    } state_t;

endpackage

// File: rtl/tile_transpose_buffer.sv
// 8x8 bit tile store: row write port, combinational row + column read port.
module tile_transpose_buffer
    import edge_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [CNT_W-1:0]  waddr,
    input  logic [TILE_N-1:0] wdata,
    input  logic [CNT_W-1:0]  raddr,
    output logic [TILE_N-1:0] row_c,
    output logic [TILE_N-1:0] col_c
);

    logic [TILE_N-1:0] mem [TILE_N];

    // Contents are don't-care until fully loaded, so no reset on the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        row_c = mem[raddr];
        col_c = '0;
        for (int i = 0; i < TILE_N; i++) begin
            col_c[i] = mem[i][raddr];
        end
    end

endmodule

// File: rtl/edge_tile_feeder.sv
// Loads an 8x8 binary tile row by row, then streams rows and columns to the
// directional edge detector and sequences its control pins per tile.
module edge_tile_feeder
    import edge_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic        LR_MODE      = 1'b0,
    parameter logic        UD_MODE      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TILE_N-1:0]  in_row,
    input  logic               complete,
    output logic               enb,
    output logic [TILE_N-1:0]  leftRightArray,
    output logic [TILE_N-1:0]  upDownArray,
    output logic               resetBuff,
    output logic               buffLRMode,
    output logic               buffUDMode,
    output logic               busy,
    output logic [COUNT_W-1:0] tile_count
);

    localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(TILE_N - 1);
    localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   row_cnt, row_cnt_nxt;
    logic [CNT_W-1:0]   col_cnt, col_cnt_nxt;
    logic [FLUSH_W-1:0] flush_cnt, flush_cnt_nxt;
    logic               in_ready_nxt, enb_nxt, resetbuff_nxt, busy_nxt;
    logic [TILE_N-1:0]  lr_nxt, ud_nxt;
    logic [COUNT_W-1:0] tile_count_nxt;

    logic               we_c;
    logic [CNT_W-1:0]   raddr_c;
    logic [TILE_N-1:0]  row_c, col_c;

    assign buffLRMode = LR_MODE;
    assign buffUDMode = UD_MODE;

    tile_transpose_buffer u_buf (
        .clk   (clk),
        .we    (we_c),
        .waddr (row_cnt),
        .wdata (in_row),
        .raddr (raddr_c),
        .row_c (row_c),
        .col_c (col_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= LOAD;
            row_cnt        <= '0;
            col_cnt        <= '0;
            flush_cnt      <= '0;
            in_ready       <= 1'b0;
            enb            <= 1'b0;
            leftRightArray <= '0;
            upDownArray    <= '0;
            resetBuff      <= 1'b0;
            busy           <= 1'b0;
            tile_count     <= '0;
        end else begin
            state          <= state_nxt;
            row_cnt        <= row_cnt_nxt;
            col_cnt        <= col_cnt_nxt;
            flush_cnt      <= flush_cnt_nxt;
            in_ready       <= in_ready_nxt;
            enb            <= enb_nxt;
            leftRightArray <= lr_nxt;
            upDownArray    <= ud_nxt;
            resetBuff      <= resetbuff_nxt;
            busy           <= busy_nxt;
            tile_count     <= tile_count_nxt;
        end
    end

    // Outputs are computed one step ahead so each registered value lines up
    // with the state it describes; the read address is the next pair index.
    always_comb begin
        state_nxt      = state;
        row_cnt_nxt    = row_cnt;
        col_cnt_nxt    = col_cnt;
        flush_cnt_nxt  = flush_cnt;
        in_ready_nxt   = 1'b0;
        enb_nxt        = 1'b0;
        lr_nxt         = '0;
        ud_nxt         = '0;
        resetbuff_nxt  = 1'b0;
        tile_count_nxt = tile_count;
        we_c           = 1'b0;
        raddr_c        = col_cnt + CNT_W'(1);

        case (state)
            LOAD: begin
                in_ready_nxt = 1'b1;
                raddr_c      = '0;
                if (in_valid && in_ready) begin
                    we_c        = 1'b1;
                    row_cnt_nxt = row_cnt + CNT_W'(1);
                    if (row_cnt == LAST_IDX) begin
                        state_nxt    = EMIT;
                        col_cnt_nxt  = '0;
                        in_ready_nxt = 1'b0;
                        enb_nxt      = 1'b1;
                        lr_nxt       = row_c;
                        // Last row is still being written; bypass its bit 0.
                        ud_nxt       = {in_row[0], col_c[TILE_N-2:0]};
                    end
                end
            end

            EMIT: begin
                enb_nxt = 1'b1;
                if (col_cnt == LAST_IDX) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = '0;
                end else begin
                    col_cnt_nxt = col_cnt + CNT_W'(1);
                    lr_nxt      = row_c;
                    ud_nxt      = col_c;
                end
            end

            FLUSH: begin
                if (flush_cnt == LAST_FLUSH) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    flush_cnt_nxt = flush_cnt + FLUSH_W'(1);
                    enb_nxt       = 1'b1;
                end
            end

            WAIT_DONE: begin
                if (complete) begin
                    state_nxt      = CLEAR;
                    resetbuff_nxt  = 1'b1;
                    tile_count_nxt = tile_count + COUNT_W'(1);
                end
            end

            CLEAR: begin
                state_nxt    = LOAD;
                in_ready_nxt = 1'b1;
            end

            default: begin
                state_nxt = LOAD;
            end
        endcase

        busy_nxt = (state_nxt != LOAD);
    end

endmodule

// File: doc/edge_tile_feeder.md
Name: edge_tile_feeder

Overview:
Source side of the directional edge detector. Accepts an 8x8 binary pixel tile as 8 streamed row words through a valid/ready handshake and stores it. It then drives the detector's left-right input with tile rows and its up-down input with tile columns (an on-the-fly transpose), one row/column pair per cycle. It also sequences the detector control pins (enb, resetBuff, buffLRMode, buffUDMode) and waits for the detector's complete before accepting the next tile.

Parameters:
FLUSH_CYCLES, 2, cycles enb stays high after the 8th pair, with zero arrays, to drain the detector/filter pipeline (1..15).
LR_MODE, 1'b0, constant value driven on buffLRMode.
UD_MODE, 1'b0, constant value driven on buffUDMode.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  in_row holds a valid tile row
in_ready  out  1  feeder can accept a row this cycle
in_row  in  8  tile row; bit i = pixel column i
complete  in  1  detector finished current tile (level, sampled each cycle)
enb  out  1  detector enable
leftRightArray  out  8  row k of tile
upDownArray  out  8  column k of tile; bit i = row i, column k
resetBuff  out  1  one-cycle pulse clearing detector buffers between tiles
buffLRMode  out  1  = LR_MODE
buffUDMode  out  1  = UD_MODE
busy  out  1  high in any state except LOAD
tile_count  out  16  tiles fully completed, wraps 16'hFFFF -> 0

Behaviour:
- Reset values: in_ready=0, enb=0, both arrays=8'h00, resetBuff=0, busy=0, tile_count=0, state=LOAD, row/col counters=0. Tile storage need not be cleared. in_ready rises on the first clock edge after reset deasserts.
- All outputs are registered except buffLRMode/buffUDMode, which are constants.
- States:
  - LOAD: in_ready=1. A row is accepted on a rising edge with in_valid&in_ready; it is stored in mem[row_cnt] and row_cnt increments. in_valid gaps are allowed; row_cnt holds during them. On acceptance of row 7, go to EMIT with col_cnt=0 and in_ready=0 from the next cycle.
  - EMIT: 8 cycles, k=0..7, with enb=1, leftRightArray=mem[k], and upDownArray[i]=mem[i][k]. The first enb cycle is the cycle after row 7 is accepted, giving a latency of 1. After k=7, go to FLUSH.
  - FLUSH: FLUSH_CYCLES cycles with enb=1 and arrays=8'h00. Then go to WAIT_DONE.
  - WAIT_DONE: enb=0, arrays=0. When complete is sampled 1, go to CLEAR.
  - CLEAR: exactly one cycle with resetBuff=1 and tile_count+1, then go to LOAD.
- in_ready=0 in every state except LOAD. in_valid outside LOAD is ignored and no data is lost (the sender must hold).
- complete asserted before WAIT_DONE is ignored. If complete is already high on entry to WAIT_DONE, exit after one cycle.
- Reset asserted mid-operation (any state) aborts the tile immediately: partial rows are discarded, outputs go to reset values asynchronously, and tile_count is cleared.
- Simultaneous events: in LOAD, row 7 acceptance and the EMIT transition are the same edge; there is no extra bubble.
- Tile period with no stalls = 8 (load) + 8 (emit) + FLUSH_CYCLES + wait + 1.

Decomposition:
- Shared package edge_pkg:
  - TILE_N=8.
  - State enum: LOAD, EMIT, FLUSH, WAIT_DONE, CLEAR.
  - Counter width localparam (3 bits).
- Sub-module tile_transpose_buffer: 8x8 flop array with a row write port (we, waddr[2:0], wdata[7:0]) and a combinational read port (raddr[2:0]) that returns both row[raddr] and column[raddr]. The top-level FSM registers these reads into the outputs.

Test Plan:
- Identity tile: rows in_row = 8'h01<<r for r=0..7, no gaps. On 8 consecutive enb cycles, leftRightArray = upDownArray = 8'h01,8'h02,…,8'h80. Then 2 flush cycles with arrays=0, then enb=0.
- Column pattern: all rows 8'hF0. leftRightArray=8'hF0 for k=0..7. upDownArray=8'h00 for k=0..3 and 8'hFF for k=4..7.
- Handshake gaps/backpressure: in_valid toggled 1,0,1,… over 16 cycles gives exactly 8 rows accepted. in_valid held high during EMIT/WAIT_DONE shows in_ready=0 and no row overwrites mem (next tile starts with the held row).
- Completion hold-off: complete held low for 20 cycles after FLUSH keeps the feeder in WAIT_DONE with enb=0. Raising complete gives a resetBuff pulse of exactly 1 cycle, tile_count 0->1, and in_ready=1 the following cycle.
- Reset mid-EMIT: assert reset at k=3. All outputs are 0 immediately. After release, load a new tile; the output matches the new tile only, and tile_count=0.
- Wrap: force/preload tile_count=16'hFFFF, run one tile, and check tile_count=16'h0000.
